// File: rtl/rob_multi_commit.sv
// Reorder buffer with N CDB ports, same-cycle operand bypass, branch/JALR
// redirect checking and up to two in-order retirements per cycle.
module rob_multi_commit #(
  parameter int DEPTH    = 16,
  parameter int ID_W     = 5,
  parameter int XLEN     = 32,
  parameter int NUM_CDB  = 2,
  parameter int COMMIT_W = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     alloc_valid_in,
  output logic                     alloc_ready_out,
  output logic [ID_W-1:0]          alloc_id_out,
  input  logic [2:0]               alloc_kind_in,
  input  logic [4:0]               alloc_rd_in,
  input  logic [XLEN-1:0]          alloc_pc_in,
  input  logic [XLEN-1:0]          alloc_value_in,
  input  logic                     alloc_pred_in,
  input  logic [XLEN-1:0]          alloc_target_in,
  input  logic                     alloc_rvc_in,
  input  logic [NUM_CDB-1:0]       cdb_valid_in,
  input  logic [NUM_CDB*ID_W-1:0]  cdb_id_in,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_value_in,
  input  logic [NUM_CDB-1:0]       cdb_taken_in,
  input  logic [2*ID_W-1:0]        qry_id_in,
  output logic [1:0]               qry_ready_out,
  output logic [2*XLEN-1:0]        qry_value_out,
  output logic [COMMIT_W-1:0]      cmt_valid_out,
  output logic [COMMIT_W*ID_W-1:0] cmt_id_out,
  output logic [COMMIT_W*5-1:0]    cmt_rd_out,
  output logic [COMMIT_W*XLEN-1:0] cmt_value_out,
  output logic                     mem_head_out,
  output logic [ID_W-1:0]          mem_head_id_out,
  output logic                     flush_out,
  output logic [XLEN-1:0]          flush_pc_out,
  output logic [ID_W:0]            count_out,
  output logic                     empty_out,
  output logic                     full_out
);
  localparam logic [2:0] K_LOAD = 3'd1, K_STORE = 3'd2, K_BRANCH = 3'd3,
                         K_JALR = 3'd4, K_DONE = 3'd5;
  localparam logic [ID_W-1:0] ID_ONE = ID_W'(1);

  // Slot 0 is unused so that IDs index the arrays directly.
  logic            busy_r   [0:DEPTH];
  logic            done_r   [0:DEPTH];
  logic [2:0]      kind_r   [0:DEPTH];
  logic [4:0]      rd_r     [0:DEPTH];
  logic [XLEN-1:0] pc_r     [0:DEPTH];
  logic [XLEN-1:0] value_r  [0:DEPTH];
  logic [XLEN-1:0] target_r [0:DEPTH];
  logic            pred_r   [0:DEPTH];
  logic            rvc_r    [0:DEPTH];
  logic            taken_r  [0:DEPTH];
  logic [ID_W-1:0] head_r, tail_r;
  logic [ID_W:0]   count_r;

  logic [ID_W-1:0] h1_s;
  logic [ID_W-1:0] slot_id_s [0:1];
  logic [1:0]      slot_v_s;
  logic            flush_s, alloc_acc_s;
  logic [XLEN-1:0] flush_pc_s;
  logic [1:0]      ret_n_s;

  function automatic logic [ID_W-1:0] nxt_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(DEPTH)) ? ID_ONE : id + ID_ONE;
  endfunction

  function automatic logic id_ok(input logic [ID_W-1:0] id);
    return (id != {ID_W{1'b0}}) && (id <= ID_W'(DEPTH));
  endfunction

  function automatic logic in_order_only(input logic [2:0] kind);
    return (kind == K_BRANCH) || (kind == K_JALR) || (kind == K_LOAD) || (kind == K_STORE);
  endfunction

  function automatic logic [XLEN-1:0] ilen(input logic rvc);
    return rvc ? XLEN'(2) : XLEN'(4);
  endfunction

  assign full_out        = (count_r == (ID_W+1)'(DEPTH));
  assign empty_out       = (count_r == {(ID_W+1){1'b0}});
  assign count_out       = count_r;
  assign alloc_ready_out = ~full_out;
  assign alloc_id_out    = tail_r;
  assign flush_out       = flush_s;
  assign flush_pc_out    = flush_pc_s;
  assign mem_head_out    = busy_r[head_r] & ~done_r[head_r] &
                           ((kind_r[head_r] == K_LOAD) || (kind_r[head_r] == K_STORE));
  assign mem_head_id_out = mem_head_out ? head_r : {ID_W{1'b0}};
  assign h1_s            = nxt_id(head_r);
  assign alloc_acc_s     = alloc_valid_in & ~full_out & rdy_in & ~flush_s;
  assign ret_n_s         = 2'(slot_v_s[0]) + 2'(slot_v_s[1]);

  // Retirement decision and redirect for the head entry.
  always_comb begin
    slot_id_s[0] = head_r;
    slot_id_s[1] = h1_s;
    slot_v_s     = 2'b00;
    flush_s      = 1'b0;
    flush_pc_s   = {XLEN{1'b0}};
    slot_v_s[0]  = busy_r[head_r] & done_r[head_r] & rdy_in;
    if (COMMIT_W == 2) begin
      slot_v_s[1] = slot_v_s[0] & busy_r[h1_s] & done_r[h1_s] &
                    ~in_order_only(kind_r[head_r]) & ~in_order_only(kind_r[h1_s]);
    end else begin
      slot_v_s[1] = 1'b0;
    end
    if (slot_v_s[0] && kind_r[head_r] == K_BRANCH) begin
      flush_s = (taken_r[head_r] != pred_r[head_r]);
      if (flush_s) begin
        flush_pc_s = taken_r[head_r] ? target_r[head_r] : pc_r[head_r] + ilen(rvc_r[head_r]);
      end else begin
        flush_pc_s = {XLEN{1'b0}};
      end
    end else if (slot_v_s[0] && kind_r[head_r] == K_JALR) begin
      flush_s    = 1'b1;
      flush_pc_s = target_r[head_r] & ~XLEN'(1);
    end else begin
      flush_s = 1'b0;
    end
  end

  // Commit port outputs, zeroed for idle slots.
  always_comb begin
    cmt_valid_out = '0;
    cmt_id_out    = '0;
    cmt_rd_out    = '0;
    cmt_value_out = '0;
    for (int c = 0; c < COMMIT_W; c++) begin
      if (slot_v_s[c]) begin
        cmt_valid_out[c]              = 1'b1;
        cmt_id_out[c*ID_W +: ID_W]    = slot_id_s[c];
        cmt_rd_out[c*5 +: 5]          = rd_r[slot_id_s[c]];
        cmt_value_out[c*XLEN +: XLEN] = value_r[slot_id_s[c]];
      end else begin
        cmt_valid_out[c] = 1'b0;
      end
    end
  end

  // Operand queries; a live CDB result overrides the stored value.
  always_comb begin
    qry_ready_out = 2'b00;
    qry_value_out = '0;
    for (int q = 0; q < 2; q++) begin
      if (id_ok(qry_id_in[q*ID_W +: ID_W])) begin
        if (done_r[qry_id_in[q*ID_W +: ID_W]]) begin
          qry_ready_out[q]              = 1'b1;
          qry_value_out[q*XLEN +: XLEN] = value_r[qry_id_in[q*ID_W +: ID_W]];
        end else begin
          qry_ready_out[q] = 1'b0;
        end
        for (int p = NUM_CDB - 1; p >= 0; p--) begin
          if (cdb_valid_in[p] && cdb_id_in[p*ID_W +: ID_W] == qry_id_in[q*ID_W +: ID_W]) begin
            qry_ready_out[q]              = 1'b1;
            qry_value_out[q*XLEN +: XLEN] = cdb_value_in[p*XLEN +: XLEN];
          end else begin
            qry_ready_out[q] = qry_ready_out[q];
          end
        end
      end else begin
        qry_ready_out[q] = 1'b0;
      end
    end
  end

  // Entry state, pointers and occupancy.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i <= DEPTH; i++) begin
        busy_r[i]   <= 1'b0;
        done_r[i]   <= 1'b0;
        kind_r[i]   <= 3'd0;
        rd_r[i]     <= 5'd0;
        pc_r[i]     <= {XLEN{1'b0}};
        value_r[i]  <= {XLEN{1'b0}};
        target_r[i] <= {XLEN{1'b0}};
        pred_r[i]   <= 1'b0;
        rvc_r[i]    <= 1'b0;
        taken_r[i]  <= 1'b0;
      end
      head_r  <= ID_ONE;
      tail_r  <= ID_ONE;
      count_r <= {(ID_W+1){1'b0}};
    end else if (rdy_in) begin
      if (flush_s) begin
        for (int i = 0; i <= DEPTH; i++) begin
          busy_r[i] <= 1'b0;
          done_r[i] <= 1'b0;
        end
        head_r  <= ID_ONE;
        tail_r  <= ID_ONE;
        count_r <= {(ID_W+1){1'b0}};
      end else begin
        // Descending order so the lowest port's write lands last.
        for (int p = NUM_CDB - 1; p >= 0; p--) begin
          if (cdb_valid_in[p] && id_ok(cdb_id_in[p*ID_W +: ID_W]) && busy_r[cdb_id_in[p*ID_W +: ID_W]]) begin
            done_r[cdb_id_in[p*ID_W +: ID_W]]  <= 1'b1;
            taken_r[cdb_id_in[p*ID_W +: ID_W]] <= cdb_taken_in[p];
            if (kind_r[cdb_id_in[p*ID_W +: ID_W]] == K_JALR) begin
              target_r[cdb_id_in[p*ID_W +: ID_W]] <= cdb_value_in[p*XLEN +: XLEN];
            end else begin
              value_r[cdb_id_in[p*ID_W +: ID_W]] <= cdb_value_in[p*XLEN +: XLEN];
            end
          end
        end
        if (slot_v_s[0]) begin
          busy_r[head_r] <= 1'b0;
          done_r[head_r] <= 1'b0;
        end
        if (slot_v_s[1]) begin
          busy_r[h1_s] <= 1'b0;
          done_r[h1_s] <= 1'b0;
          head_r       <= nxt_id(h1_s);
        end else if (slot_v_s[0]) begin
          head_r <= h1_s;
        end
        if (alloc_acc_s) begin
          busy_r[tail_r]   <= 1'b1;
          done_r[tail_r]   <= (alloc_kind_in == K_DONE);
          kind_r[tail_r]   <= alloc_kind_in;
          rd_r[tail_r]     <= alloc_rd_in;
          pc_r[tail_r]     <= alloc_pc_in;
          target_r[tail_r] <= alloc_target_in;
          pred_r[tail_r]   <= alloc_pred_in;
          rvc_r[tail_r]    <= alloc_rvc_in;
          taken_r[tail_r]  <= 1'b0;
          case (alloc_kind_in)
            K_DONE:  value_r[tail_r] <= alloc_value_in;
            K_JALR:  value_r[tail_r] <= alloc_pc_in + ilen(alloc_rvc_in);
            default: value_r[tail_r] <= {XLEN{1'b0}};
          endcase
          tail_r <= nxt_id(tail_r);
        end
        count_r <= count_r + (ID_W+1)'(alloc_acc_s) - (ID_W+1)'(ret_n_s);
      end
    end
  end
endmodule

// File: tb/tb_rob_multi_commit.sv
// Directed bench for rob_multi_commit at DEPTH=4: allocation, CDB, bypass,
// dual commit, branch/JALR redirect, wrap, async reset and rdy_in stall.
module tb_rob_multi_commit;
  localparam int DEPTH = 4, ID_W = 3, XLEN = 32, NUM_CDB = 2, COMMIT_W = 2;

  logic                     clk_in = 1'b0;
  logic                     rst_in, rdy_in;
  logic                     alloc_valid_in, alloc_ready_out;
  logic [ID_W-1:0]          alloc_id_out;
  logic [2:0]               alloc_kind_in;
  logic [4:0]               alloc_rd_in;
  logic [XLEN-1:0]          alloc_pc_in, alloc_value_in, alloc_target_in;
  logic                     alloc_pred_in, alloc_rvc_in;
  logic [NUM_CDB-1:0]       cdb_valid_in, cdb_taken_in;
  logic [NUM_CDB*ID_W-1:0]  cdb_id_in;
  logic [NUM_CDB*XLEN-1:0]  cdb_value_in;
  logic [2*ID_W-1:0]        qry_id_in;
  logic [1:0]               qry_ready_out;
  logic [2*XLEN-1:0]        qry_value_out;
  logic [COMMIT_W-1:0]      cmt_valid_out;
  logic [COMMIT_W*ID_W-1:0] cmt_id_out;
  logic [COMMIT_W*5-1:0]    cmt_rd_out;
  logic [COMMIT_W*XLEN-1:0] cmt_value_out;
  logic                     mem_head_out, flush_out, empty_out, full_out;
  logic [ID_W-1:0]          mem_head_id_out;
  logic [XLEN-1:0]          flush_pc_out;
  logic [ID_W:0]            count_out;

  int tests = 0;
  int fails = 0;

  rob_multi_commit #(.DEPTH(DEPTH), .ID_W(ID_W), .XLEN(XLEN), .NUM_CDB(NUM_CDB), .COMMIT_W(COMMIT_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .alloc_valid_in(alloc_valid_in), .alloc_ready_out(alloc_ready_out), .alloc_id_out(alloc_id_out),
    .alloc_kind_in(alloc_kind_in), .alloc_rd_in(alloc_rd_in), .alloc_pc_in(alloc_pc_in),
    .alloc_value_in(alloc_value_in), .alloc_pred_in(alloc_pred_in), .alloc_target_in(alloc_target_in),
    .alloc_rvc_in(alloc_rvc_in), .cdb_valid_in(cdb_valid_in), .cdb_id_in(cdb_id_in),
    .cdb_value_in(cdb_value_in), .cdb_taken_in(cdb_taken_in), .qry_id_in(qry_id_in),
    .qry_ready_out(qry_ready_out), .qry_value_out(qry_value_out), .cmt_valid_out(cmt_valid_out),
    .cmt_id_out(cmt_id_out), .cmt_rd_out(cmt_rd_out), .cmt_value_out(cmt_value_out),
    .mem_head_out(mem_head_out), .mem_head_id_out(mem_head_id_out), .flush_out(flush_out),
    .flush_pc_out(flush_pc_out), .count_out(count_out), .empty_out(empty_out), .full_out(full_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic alloc(input logic [2:0] kind, input logic [4:0] rd, input logic [31:0] pc,
                       input logic [31:0] val, input logic pred, input logic [31:0] tgt, input logic rvc);
    alloc_valid_in = 1'b1; alloc_kind_in = kind; alloc_rd_in = rd; alloc_pc_in = pc;
    alloc_value_in = val; alloc_pred_in = pred; alloc_target_in = tgt; alloc_rvc_in = rvc;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; alloc_valid_in = 1'b0; alloc_kind_in = 3'd0; alloc_rd_in = 5'd0;
    alloc_pc_in = 32'd0; alloc_value_in = 32'd0; alloc_pred_in = 1'b0; alloc_target_in = 32'd0;
    alloc_rvc_in = 1'b0; cdb_valid_in = 2'b00; cdb_id_in = 6'd0; cdb_value_in = 64'd0;
    cdb_taken_in = 2'b00; qry_id_in = 6'd0;
    #12;
    chk("rst_ready", 64'(alloc_ready_out), 64'd1);
    chk("rst_id", 64'(alloc_id_out), 64'd1);
    chk("rst_empty", 64'(empty_out), 64'd1);
    chk("rst_count", 64'(count_out), 64'd0);
    chk("rst_misc", 64'({full_out, cmt_valid_out, flush_out, mem_head_out, mem_head_id_out}), 64'd0);
    rst_in = 1'b1;
    cyc();

    // Fill to DEPTH, then one more allocation is ignored.
    for (int i = 1; i <= 4; i++) begin
      chk("fill_id", 64'(alloc_id_out), 64'(i));
      alloc(3'd0, 5'(i), 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
      cyc();
    end
    chk("full", 64'({full_out, alloc_ready_out}), 64'b10);
    cyc();
    alloc_valid_in = 1'b0;
    chk("full_count", 64'(count_out), 64'd4);
    chk("full_tail", 64'(alloc_id_out), 64'd1);

    // Drain with both CDB ports; dual retirement each cycle.
    cdb_valid_in = 2'b11; cdb_id_in = {3'd2, 3'd1}; cdb_value_in = {32'hA2, 32'hA1};
    cyc();
    cdb_id_in = {3'd4, 3'd3}; cdb_value_in = {32'hA4, 32'hA3};
    #1;
    chk("drain_v12", 64'(cmt_valid_out), 64'b11);
    chk("drain_val12", 64'(cmt_value_out), {32'hA2, 32'hA1});
    cyc();
    cdb_valid_in = 2'b00;
    chk("drain_cnt", 64'(count_out), 64'd2);
    #1;
    chk("drain_id34", 64'(cmt_id_out), 64'({3'd4, 3'd3}));
    chk("drain_val34", 64'(cmt_value_out), {32'hA4, 32'hA3});
    cyc();
    chk("drain_empty", 64'({count_out, empty_out}), 64'b0000_1);

    // Out-of-order completion, then dual commit.
    alloc(3'd0, 5'd5, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc();
    alloc(3'd0, 5'd6, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc();
    alloc_valid_in = 1'b0;
    cdb_valid_in = 2'b01; cdb_id_in = {3'd0, 3'd2}; cdb_value_in = {32'h0, 32'h22};
    cyc();
    cdb_valid_in = 2'b10; cdb_id_in = {3'd1, 3'd0}; cdb_value_in = {32'h11, 32'h0};
    #1;
    chk("ooo_wait", 64'(cmt_valid_out), 64'b00);
    cyc();
    cdb_valid_in = 2'b00;
    #1;
    chk("ooo_v", 64'(cmt_valid_out), 64'b11);
    chk("ooo_val", 64'(cmt_value_out), {32'h22, 32'h11});
    chk("ooo_rd", 64'(cmt_rd_out), 64'({5'd6, 5'd5}));
    cyc();
    chk("ooo_empty", 64'({count_out, empty_out}), 64'b0000_1);

    // Same-cycle bypass, both ports on one ID: port 0 wins.
    alloc(3'd0, 5'd7, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc();
    alloc_valid_in = 1'b0;
    qry_id_in = {3'd0, 3'd3};
    cdb_valid_in = 2'b11; cdb_id_in = {3'd3, 3'd3}; cdb_value_in = {32'h5555, 32'hABCD};
    #1;
    chk("byp_rdy", 64'(qry_ready_out), 64'b01);
    chk("byp_val", 64'(qry_value_out), {32'h0, 32'hABCD});
    cyc();
    cdb_valid_in = 2'b00;
    #1;
    chk("qry_done", 64'({qry_ready_out, qry_value_out[31:0]}), 64'({2'b01, 32'hABCD}));
    chk("qry_cmt", 64'({cmt_valid_out, cmt_id_out[2:0]}), 64'({2'b01, 3'd3}));
    cyc();
    qry_id_in = 6'd0;

    // Mispredicted branch (predicted taken, not taken) at ID 4, younger ALU at ID 1.
    alloc(3'd3, 5'd0, 32'h100, 32'h0, 1'b1, 32'h180, 1'b0);
    cyc();
    alloc(3'd0, 5'd9, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc();
    alloc_valid_in = 1'b0;
    chk("br_count", 64'(count_out), 64'd2);
    cdb_valid_in = 2'b01; cdb_id_in = {3'd0, 3'd4}; cdb_taken_in = 2'b00;
    cyc();
    cdb_valid_in = 2'b00;
    alloc(3'd0, 5'd1, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("br_flush", 64'({flush_out, flush_pc_out}), 64'({1'b1, 32'h104}));
    chk("br_cmt", 64'({cmt_valid_out, cmt_id_out[2:0]}), 64'({2'b01, 3'd4}));
    cyc();
    alloc_valid_in = 1'b0;
    chk("br_clear", 64'({count_out, alloc_id_out, empty_out}), 64'({4'd0, 3'd1, 1'b1}));

    // Same with a compressed branch.
    alloc(3'd3, 5'd0, 32'h100, 32'h0, 1'b1, 32'h180, 1'b1);
    cyc();
    alloc_valid_in = 1'b0;
    cdb_valid_in = 2'b01; cdb_id_in = {3'd0, 3'd1}; cdb_taken_in = 2'b00;
    cyc();
    cdb_valid_in = 2'b00;
    #1;
    chk("rvc_flush", 64'({flush_out, flush_pc_out}), 64'({1'b1, 32'h102}));
    cyc();

    // JALR: target bit 0 cleared, writeback pc+4.
    alloc(3'd4, 5'd1, 32'h200, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc();
    alloc_valid_in = 1'b0;
    cdb_valid_in = 2'b01; cdb_id_in = {3'd0, 3'd1}; cdb_value_in = {32'h0, 32'h305};
    cyc();
    cdb_valid_in = 2'b00;
    #1;
    chk("jalr_flush", 64'({flush_out, flush_pc_out}), 64'({1'b1, 32'h304}));
    chk("jalr_wb", 64'(cmt_value_out[31:0]), 64'h204);
    cyc();

    // Wrap: six pre-resolved entries one at a time -> IDs 1,2,3,4,1,2.
    for (int i = 0; i < 6; i++) begin
      chk("wrap_id", 64'(alloc_id_out), 64'((i % 4) + 1));
      alloc(3'd5, 5'd2, 32'h0, 32'(i + 16), 1'b0, 32'h0, 1'b0);
      cyc();
      alloc_valid_in = 1'b0;
      #1;
      chk("wrap_cmt", 64'({cmt_valid_out, cmt_value_out[31:0]}), 64'({2'b01, 32'(i + 16)}));
      cyc();
    end

    // Unresolved LOAD at head (ID 3).
    alloc(3'd1, 5'd4, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc();
    chk("mem_head", 64'({mem_head_out, mem_head_id_out, cmt_valid_out}), 64'({1'b1, 3'd3, 2'b00}));
    alloc(3'd0, 5'd4, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc();
    cyc();
    alloc_valid_in = 1'b0;
    chk("pre_rst_cnt", 64'(count_out), 64'd3);

    // Asynchronous reset mid-cycle.
    #2;
    rst_in = 1'b0;
    #1;
    chk("async_rst", 64'({count_out, alloc_id_out, empty_out, mem_head_out}), 64'({4'd0, 3'd1, 1'b1, 1'b0}));
    #1;
    rst_in = 1'b1;
    cyc();

    // rdy_in low freezes a done head and blocks allocation.
    alloc(3'd5, 5'd3, 32'h0, 32'h77, 1'b0, 32'h0, 1'b0);
    cyc();
    rdy_in = 1'b0;
    #1;
    chk("stall_cmt", 64'({cmt_valid_out, flush_out}), 64'd0);
    cyc();
    cyc();
    chk("stall_hold", 64'({count_out, alloc_id_out}), 64'({4'd1, 3'd2}));
    rdy_in = 1'b1;
    alloc_valid_in = 1'b0;
    #1;
    chk("resume_cmt", 64'({cmt_valid_out, cmt_rd_out[4:0], cmt_value_out[31:0]}), 64'({2'b01, 5'd3, 32'h77}));
    cyc();
    chk("resume_empty", 64'({count_out, empty_out}), 64'b0000_1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
